// File: rtl/alu_pkg.sv
// Shared constants for the RV32I execute-stage ALU: widths, class codes and opcodes.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 6;

    // Operation classes carried in ALU_Control[5:3]
    localparam logic [2:0] ALU_CLS_ARITH  = 3'b000;
    localparam logic [2:0] ALU_CLS_ALT    = 3'b001;
    localparam logic [2:0] ALU_CLS_BRANCH = 3'b010;

    // Full opcodes: {class, funct3}
    localparam logic [CTRL_W-1:0] ALU_ADD  = 6'b000_000;
    localparam logic [CTRL_W-1:0] ALU_SLL  = 6'b000_001;
    localparam logic [CTRL_W-1:0] ALU_SLT  = 6'b000_010;
    localparam logic [CTRL_W-1:0] ALU_SLTU = 6'b000_011;
    localparam logic [CTRL_W-1:0] ALU_XOR  = 6'b000_100;
    localparam logic [CTRL_W-1:0] ALU_SRL  = 6'b000_101;
    localparam logic [CTRL_W-1:0] ALU_OR   = 6'b000_110;
    localparam logic [CTRL_W-1:0] ALU_AND  = 6'b000_111;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 6'b001_000;
    localparam logic [CTRL_W-1:0] ALU_SRA  = 6'b001_101;
    localparam logic [CTRL_W-1:0] ALU_BEQ  = 6'b010_000;
    localparam logic [CTRL_W-1:0] ALU_BNE  = 6'b010_001;
    localparam logic [CTRL_W-1:0] ALU_BLT  = 6'b010_100;
    localparam logic [CTRL_W-1:0] ALU_BGE  = 6'b010_101;
    localparam logic [CTRL_W-1:0] ALU_BLTU = 6'b010_110;
    localparam logic [CTRL_W-1:0] ALU_BGEU = 6'b010_111;
    localparam logic [CTRL_W-1:0] ALU_JAL  = 6'b011_111;
    localparam logic [CTRL_W-1:0] ALU_JALR = 6'b111_111;

endpackage

// File: rtl/alu_branch_cmp.sv
// Branch condition evaluator; its signed/unsigned less-than results also feed SLT/SLTU.
module alu_branch_cmp
    import alu_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              cond,
    output logic              lt_s,
    output logic              lt_u
);

    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic                     eq;

    assign a_s = a;
    assign b_s = b;

    // Shared comparators and funct3-selected branch condition
    always_comb begin
        lt_s = (a_s < b_s);
        lt_u = (a < b);
        eq   = (a == b);
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = eq;
            3'b001:  cond = !eq;
            3'b100:  cond = lt_s;
            3'b101:  cond = !lt_s;
            3'b110:  cond = lt_u;
            3'b111:  cond = !lt_u;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// RV32I execute-stage ALU: combinational result/branch plus one registered copy.
module alu
    import alu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              branch_op,
    input  logic [CTRL_W-1:0] ALU_Control,
    input  logic [DATA_W-1:0] operand_A,
    input  logic [DATA_W-1:0] operand_B,
    output logic [DATA_W-1:0] ALU_result,
    output logic              branch,
    output logic [DATA_W-1:0] ALU_result_q,
    output logic              branch_q
);

    logic [2:0]               cls;
    logic [2:0]               funct3;
    logic [4:0]               shamt;
    logic signed [DATA_W-1:0] a_s;
    logic                     cond;
    logic                     lt_s;
    logic                     lt_u;

    assign cls    = ALU_Control[5:3];
    assign funct3 = ALU_Control[2:0];
    assign shamt  = operand_B[4:0];
    assign a_s    = operand_A;

    alu_branch_cmp u_cmp (
        .funct3 (funct3),
        .a      (operand_A),
        .b      (operand_B),
        .cond   (cond),
        .lt_s   (lt_s),
        .lt_u   (lt_u)
    );

    // Result mux; branch class reports its condition in bit 0
    always_comb begin
        ALU_result = '0;
        if (cls == ALU_CLS_BRANCH) begin
            ALU_result = {{(DATA_W-1){1'b0}}, cond};
        end else begin
            case (ALU_Control)
                ALU_ADD:  ALU_result = operand_A + operand_B;
                ALU_SUB:  ALU_result = operand_A - operand_B;
                ALU_SLL:  ALU_result = operand_A << shamt;
                ALU_SLT:  ALU_result = {{(DATA_W-1){1'b0}}, lt_s};
                ALU_SLTU: ALU_result = {{(DATA_W-1){1'b0}}, lt_u};
                ALU_XOR:  ALU_result = operand_A ^ operand_B;
                ALU_SRL:  ALU_result = operand_A >> shamt;
                ALU_SRA:  ALU_result = a_s >>> shamt;
                ALU_OR:   ALU_result = operand_A | operand_B;
                ALU_AND:  ALU_result = operand_A & operand_B;
                ALU_JAL,
                ALU_JALR: ALU_result = operand_A;
                default:  ALU_result = '0;
            endcase
        end
    end

    // Branch taken only for a qualified branch-class compare
    always_comb begin
        branch = branch_op && (cls == ALU_CLS_BRANCH) && cond;
    end

    // Output stage register toward the next pipeline stage
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ALU_result_q <= '0;
            branch_q     <= 1'b0;
        end else begin
            ALU_result_q <= ALU_result;
            branch_q     <= branch;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Bench for alu: direct checks of the combinational outputs, scoreboard for the registered ones.
module tb_alu;
    import alu_pkg::*;

    logic        clock;
    logic        reset;
    logic        branch_op;
    logic [5:0]  ALU_Control;
    logic [31:0] operand_A;
    logic [31:0] operand_B;
    logic [31:0] ALU_result;
    logic        branch;
    logic [31:0] ALU_result_q;
    logic        branch_q;

    typedef struct {
        logic [31:0] res;
        logic        br;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    alu dut (
        .clock        (clock),
        .reset        (reset),
        .branch_op    (branch_op),
        .ALU_Control  (ALU_Control),
        .operand_A    (operand_A),
        .operand_B    (operand_B),
        .ALU_result   (ALU_result),
        .branch       (branch),
        .ALU_result_q (ALU_result_q),
        .branch_q     (branch_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Independent reference: {branch, result}
    function automatic logic [32:0] ref_alu(input logic [5:0] c, input logic [31:0] a,
                                            input logic [31:0] b, input logic bop);
        logic [63:0] ext;
        logic        slt, sltu, cnd;
        logic [31:0] r;
        sltu = (a < b);
        slt  = (a[31] != b[31]) ? a[31] : (a < b);
        ext  = {{32{a[31]}}, a} >> b[4:0];
        r    = 32'd0;
        cnd  = 1'b0;
        if      (c == ALU_ADD)  r = a + b;
        else if (c == ALU_SUB)  r = a + (~b) + 32'd1;
        else if (c == ALU_SLL)  r = a << b[4:0];
        else if (c == ALU_SLT)  r = {31'd0, slt};
        else if (c == ALU_SLTU) r = {31'd0, sltu};
        else if (c == ALU_XOR)  r = a ^ b;
        else if (c == ALU_SRL)  r = a >> b[4:0];
        else if (c == ALU_SRA)  r = ext[31:0];
        else if (c == ALU_OR)   r = a | b;
        else if (c == ALU_AND)  r = a & b;
        else if (c == ALU_JAL || c == ALU_JALR) r = a;
        else if (c[5:3] == 3'b010) begin
            if      (c == ALU_BEQ)  cnd = (a == b);
            else if (c == ALU_BNE)  cnd = (a != b);
            else if (c == ALU_BLT)  cnd = slt;
            else if (c == ALU_BGE)  cnd = !slt;
            else if (c == ALU_BLTU) cnd = sltu;
            else if (c == ALU_BGEU) cnd = !sltu;
            r = {31'd0, cnd};
        end
        return {bop & cnd, r};
    endfunction

    // Drive one op, check combinational outputs, then the registered copy a cycle later
    task automatic do_op(input string tag, input logic [5:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic bop,
                         input logic [31:0] exp_res, input logic exp_br);
        exp_t e;
        @(negedge clock);
        ALU_Control = c;
        operand_A   = a;
        operand_B   = b;
        branch_op   = bop;
        #1;
        check({tag, "_res"}, ALU_result, exp_res);
        check({tag, "_br"}, {31'd0, branch}, {31'd0, exp_br});
        e.res = exp_res;
        e.br  = exp_br;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_res_q"}, ALU_result_q, e.res);
            check({tag, "_br_q"}, {31'd0, branch_q}, {31'd0, e.br});
        end
    endtask

    task automatic do_ref(input string tag, input logic [5:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic bop);
        logic [32:0] m;
        m = ref_alu(c, a, b, bop);
        do_op(tag, c, a, b, bop, m[31:0], m[32]);
    endtask

    logic [5:0] ops [22];

    initial begin
        reset       = 1'b0;
        branch_op   = 1'b0;
        ALU_Control = ALU_ADD;
        operand_A   = 32'd7;
        operand_B   = 32'd3;
        @(posedge clock);
        #1;
        check("rst_res_q", ALU_result_q, 32'd0);
        check("rst_br_q", {31'd0, branch_q}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        do_op("add",      ALU_ADD,  32'd4,  32'd5,          1'b0, 32'd9,  1'b0);
        do_op("sub",      ALU_SUB,  32'd10, 32'hFFFFFFFB,   1'b0, 32'd15, 1'b0);
        do_op("add_wrap", ALU_ADD,  32'hFFFFFFFF, 32'd1,    1'b0, 32'd0,  1'b0);
        do_op("slt_a",    ALU_SLT,  32'd4,  32'd5,          1'b0, 32'd1,  1'b0);
        do_op("slt_b",    ALU_SLT,  32'd4,  32'hFFFFFFFF,   1'b0, 32'd0,  1'b0);
        do_op("slt_c",    ALU_SLT,  32'd10, 32'hFFFFFFFB,   1'b0, 32'd0,  1'b0);
        do_op("sltu",     ALU_SLTU, 32'd10, 32'hFFFFFFFB,   1'b0, 32'd1,  1'b0);
        do_op("xor",      ALU_XOR,  32'd10, 32'd7,          1'b0, 32'd13, 1'b0);
        do_op("or",       ALU_OR,   32'd10, 32'd7,          1'b0, 32'd15, 1'b0);
        do_op("and",      ALU_AND,  32'd10, 32'd7,          1'b0, 32'd2,  1'b0);
        do_op("sll",      ALU_SLL,  32'd10, 32'd1,          1'b0, 32'd20, 1'b0);
        do_op("srl",      ALU_SRL,  32'd10, 32'd1,          1'b0, 32'd5,  1'b0);
        do_op("sra",      ALU_SRA,  32'hFFFFFFF6, 32'd1,    1'b0, 32'hFFFFFFFB, 1'b0);
        do_op("sll_33",   ALU_SLL,  32'd10, 32'd33,         1'b0, 32'd20, 1'b0);
        do_op("beq",      ALU_BEQ,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'd1, 1'b1);
        do_op("bge_eq",   ALU_BGE,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'd1, 1'b1);
        do_op("bne",      ALU_BNE,  32'd4,  32'd5,          1'b1, 32'd1,  1'b1);
        do_op("blt",      ALU_BLT,  32'd4,  32'd5,          1'b1, 32'd1,  1'b1);
        do_op("bltu_a",   ALU_BLTU, 32'd4,  32'hFFFFFFFB,   1'b1, 32'd1,  1'b1);
        do_op("bltu_b",   ALU_BLTU, 32'hFFFFFFFA, 32'hFFFFFFFB, 1'b1, 32'd1, 1'b1);
        do_op("blt_neg",  ALU_BLT,  32'hFFFFFFFA, 32'hFFFFFFFB, 1'b1, 32'd1, 1'b1);
        // unsigned: 0xFFFFFFFB >= 5 is taken, 5 >= 0xFFFFFFFB is not
        do_op("bgeu_a",   ALU_BGEU, 32'hFFFFFFFB, 32'd5,    1'b1, 32'd1,  1'b1);
        do_op("bgeu_b",   ALU_BGEU, 32'd5,  32'hFFFFFFFB,   1'b1, 32'd0,  1'b0);
        do_op("bge_nt",   ALU_BGE,  32'd4,  32'd5,          1'b1, 32'd0,  1'b0);
        do_op("beq_nobop",ALU_BEQ,  32'd1,  32'd1,          1'b0, 32'd1,  1'b0);
        do_op("b_f3_010", 6'b010_010, 32'd1, 32'd1,         1'b1, 32'd0,  1'b0);
        do_op("add_bop",  ALU_ADD,  32'd3,  32'd3,          1'b1, 32'd6,  1'b0);
        do_op("jal",      ALU_JAL,  32'd5,  32'hFFFFFFFB,   1'b0, 32'd5,  1'b0);
        do_op("jalr",     ALU_JALR, 32'd5,  32'hFFFFFFFB,   1'b1, 32'd5,  1'b0);
        do_op("undef",    6'b100_000, 32'd5, 32'd6,         1'b1, 32'd0,  1'b0);
        do_op("alt_undef",6'b001_001, 32'd5, 32'd6,         1'b0, 32'd0,  1'b0);

        // Async reset between edges: registered outputs clear without a clock edge
        do_op("pre_rst",  ALU_BEQ,  32'd9,  32'd9,          1'b1, 32'd1,  1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_res_q", ALU_result_q, 32'd0);
        check("async_rst_br_q", {31'd0, branch_q}, 32'd0);
        @(posedge clock);
        #1;
        check("hold_rst_res_q", ALU_result_q, 32'd0);
        check("hold_rst_br_q", {31'd0, branch_q}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        do_op("post_rst", ALU_ADD,  32'd100, 32'd23,        1'b0, 32'd123, 1'b0);

        ops = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
                ALU_OR, ALU_AND, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU,
                ALU_JAL, ALU_JALR, 6'b010_011, 6'b001_110, 6'b101_010, 6'b011_000};
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 3 == 0) ? (ra ^ {27'd0, 5'($urandom_range(0, 1))}) : $urandom;
            do_ref("rand", ops[$urandom_range(0, 21)], ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
